// File: rtl/euler_integrator.sv
// Sequential fixed-point Euler integrator: x[n+1] = x[n] + (dx[n] >>> HShift) for N programmed steps.
// Define EULER_INTEGRATOR_SATURATE_EN to clamp the sum instead of wrapping on overflow.
module euler_integrator #(
  parameter int Width      = 32,
  parameter int HShift     = 8,
  parameter int StepsWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [StepsWidth-1:0] num_steps_i,
  input  logic [Width-1:0]      x0_i,
  input  logic [Width-1:0]      dx_i,
  input  logic                  dx_valid_i,
  output logic                  dx_ready_o,
  output logic [Width-1:0]      x_o,
  output logic                  x_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [Width-1:0]        x_q, x_d, x_next, dx_sh;
  logic [StepsWidth-1:0]   cnt_q, cnt_d;
  logic                    x_valid_q, x_valid_d;
  logic                    done_q, done_d;
  logic                    handshake;

  assign dx_ready_o = (state_q == RUN);
  assign busy_o     = (state_q != IDLE);
  assign handshake  = dx_valid_i && dx_ready_o;

  // Step size h = 2^-HShift; arithmetic shift floors toward minus infinity.
  assign dx_sh = $signed(dx_i) >>> HShift;

`ifdef EULER_INTEGRATOR_SATURATE_EN
  logic [Width:0] sum_ext;

  assign sum_ext = {x_q[Width-1], x_q} + {dx_sh[Width-1], dx_sh};

  // Top two bits disagree only on signed overflow; the extra bit holds the true sign.
  always_comb begin
    x_next = sum_ext[Width-1:0];
    if (sum_ext[Width] != sum_ext[Width-1]) begin
      x_next = sum_ext[Width] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    end
  end
`else
  assign x_next = x_q + dx_sh;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    x_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d       = x0_i;
          cnt_d     = num_steps_i;
          x_valid_d = 1'b1;
          state_d   = (num_steps_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (handshake) begin
          x_d       = x_next;
          cnt_d     = cnt_q - StepsWidth'(1);
          x_valid_d = 1'b1;
          if (cnt_q == StepsWidth'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done pulse is registered alongside the x_valid pulse of the edge entering DONE.
  assign done_d = (state_d == DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      x_q       <= '0;
      cnt_q     <= '0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

  assign x_o       = x_q;
  assign x_valid_o = x_valid_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_euler_integrator.sv
// Directed, table-driven bench for euler_integrator with hand-written reset and start-ignore sequences.
module tb_euler_integrator;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] num_steps_i = '0;
  logic [31:0] x0_i = '0;
  logic [31:0] dx_i = '0;
  logic        dx_valid_i = 1'b0;
  logic        dx_ready_o;
  logic [31:0] x_o;
  logic        x_valid_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_pass   = 0;

  euler_integrator #(.Width(32), .HShift(8), .StepsWidth(16)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .num_steps_i(num_steps_i),
    .x0_i       (x0_i),
    .dx_i       (dx_i),
    .dx_valid_i (dx_valid_i),
    .dx_ready_o (dx_ready_o),
    .x_o        (x_o),
    .x_valid_o  (x_valid_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start;
    logic [15:0] num;
    logic [31:0] x0;
    logic [31:0] dx;
    logic        dv;
    logic [31:0] ex;
    logic        ev;
    logic        ed;
    logic        eb;
    logic        er;
  } vec_t;

  vec_t vecs[$];

`ifdef EULER_INTEGRATOR_SATURATE_EN
  localparam logic [31:0] OvfPos = 32'h7FFF_FFFF;
  localparam logic [31:0] OvfNeg = 32'h8000_0000;
`else
  localparam logic [31:0] OvfPos = 32'h8000_0FFF;
  localparam logic [31:0] OvfNeg = 32'h7FFF_F000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input logic st, input logic [15:0] num, input logic [31:0] x0,
                     input logic [31:0] dx, input logic dv, input logic [31:0] ex,
                     input logic ev, input logic ed, input logic eb, input logic er);
    vec_t v;
    v.start = st; v.num = num; v.x0 = x0; v.dx = dx; v.dv = dv;
    v.ex = ex; v.ev = ev; v.ed = ed; v.eb = eb; v.er = er;
    vecs.push_back(v);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] ex, input logic ev,
                           input logic ed, input logic eb, input logic er);
    check({tag, "_x"},     x_o,               ex);
    check({tag, "_valid"}, {31'b0, x_valid_o}, {31'b0, ev});
    check({tag, "_done"},  {31'b0, done_o},    {31'b0, ed});
    check({tag, "_busy"},  {31'b0, busy_o},    {31'b0, eb});
    check({tag, "_ready"}, {31'b0, dx_ready_o},{31'b0, er});
  endtask

  initial begin
    // Basic run: x0=0, N=3, dx=+1.0 held valid.
    add(1, 3, 32'h0, 32'h0010_0000, 1, 32'h0000_0000, 1, 0, 1, 1);
    add(0, 0, 32'h0, 32'h0010_0000, 1, 32'h0000_1000, 1, 0, 1, 1);
    add(0, 0, 32'h0, 32'h0010_0000, 1, 32'h0000_2000, 1, 0, 1, 1);
    add(0, 0, 32'h0, 32'h0010_0000, 1, 32'h0000_3000, 1, 1, 1, 0);
    add(0, 0, 32'h0, 32'h0010_0000, 1, 32'h0000_3000, 0, 0, 0, 0);
    // Negative dx with stalls: valid pattern 1,0,0,1.
    add(1, 2, 32'h0020_0000, 32'hFFF0_0000, 0, 32'h0020_0000, 1, 0, 1, 1);
    add(0, 0, 32'h0, 32'hFFF0_0000, 1, 32'h001F_F000, 1, 0, 1, 1);
    add(0, 0, 32'h0, 32'hFFF0_0000, 0, 32'h001F_F000, 0, 0, 1, 1);
    add(0, 0, 32'h0, 32'hFFF0_0000, 0, 32'h001F_F000, 0, 0, 1, 1);
    add(0, 0, 32'h0, 32'hFFF0_0000, 1, 32'h001F_E000, 1, 1, 1, 0);
    add(0, 0, 32'h0, 32'hFFF0_0000, 1, 32'h001F_E000, 0, 0, 0, 0);
    add(0, 0, 32'h0, 32'hFFF0_0000, 1, 32'h001F_E000, 0, 0, 0, 0);
    // Zero steps: load, done in the same cycle, ready never high.
    add(1, 0, 32'h1234_5678, 32'h0010_0000, 1, 32'h1234_5678, 1, 1, 1, 0);
    add(0, 0, 32'h0, 32'h0010_0000, 1, 32'h1234_5678, 0, 0, 0, 0);
    // Positive overflow.
    add(1, 1, 32'h7FFF_FFFF, 32'h0010_0000, 0, 32'h7FFF_FFFF, 1, 0, 1, 1);
    add(0, 0, 32'h0, 32'h0010_0000, 1, OvfPos, 1, 1, 1, 0);
    add(0, 0, 32'h0, 32'h0010_0000, 0, OvfPos, 0, 0, 0, 0);
    // Negative overflow.
    add(1, 1, 32'h8000_0000, 32'hFFF0_0000, 0, 32'h8000_0000, 1, 0, 1, 1);
    add(0, 0, 32'h0, 32'hFFF0_0000, 1, OvfNeg, 1, 1, 1, 0);
    add(0, 0, 32'h0, 32'hFFF0_0000, 0, OvfNeg, 0, 0, 0, 0);

    // Asynchronous reset from power-up, observed without a clock edge.
    #2 rst_ni = 1'b0;
    #1 check_all("reset", 32'h0, 0, 0, 0, 0);
    repeat (2) tick();
    #2 rst_ni = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      start_i     = vecs[i].start;
      num_steps_i = vecs[i].num;
      x0_i        = vecs[i].x0;
      dx_i        = vecs[i].dx;
      dx_valid_i  = vecs[i].dv;
      tick();
      check_all($sformatf("v%0d", i), vecs[i].ex, vecs[i].ev, vecs[i].ed, vecs[i].eb, vecs[i].er);
    end
    start_i = 1'b0; dx_valid_i = 1'b0;
    tick();

    // Start during RUN must not reload x or the step count.
    start_i = 1'b1; num_steps_i = 16'd3; x0_i = 32'h100; dx_i = 32'h0010_0000; dx_valid_i = 1'b1;
    tick();
    check("sig_load_x", x_o, 32'h100);
    num_steps_i = 16'd7; x0_i = 32'h55;
    tick();
    check("sig_step1_x", x_o, 32'h1100);
    start_i = 1'b0;
    tick();
    check("sig_step2_x", x_o, 32'h2100);
    tick();
    check("sig_step3_x", x_o, 32'h3100);
    check("sig_step3_done", {31'b0, done_o}, 32'h1);
    tick();
    check_all("sig_after", 32'h3100, 0, 0, 0, 0);

    // Mid-run asynchronous reset after 2 of 5 steps, then a clean restart.
    start_i = 1'b1; num_steps_i = 16'd5; x0_i = 32'h0040_0000;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    check("mr_step2_x", x_o, 32'h0040_2000);
    #2 rst_ni = 1'b0;
    #1 check_all("mr_reset", 32'h0, 0, 0, 0, 0);
    #2 rst_ni = 1'b1;
    start_i = 1'b1; num_steps_i = 16'd1; x0_i = 32'h10;
    tick();
    check_all("mr_load", 32'h10, 1, 0, 1, 1);
    start_i = 1'b0;
    tick();
    check_all("mr_step", 32'h1010, 1, 1, 1, 0);
    dx_valid_i = 1'b0;
    tick();
    check_all("mr_idle", 32'h1010, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
